vpg_timing_core: RTL and testbench
==================================

// Module: vpg_timing_core
// PURPOSE
//  Parametrised video timing generator, successor to the fixed-mode pattern timing path.
//  Timing is runtime-programmable through a valid/ready config port, and a new timing set
//  takes effect only at a frame boundary, so a mode change never produces a torn frame.
//  Produces registered HS/VS/DE, pixel x/y, frame/line strobes and an N-way vertical band
//  index for overlay/pattern logic. Sits between the pixel-clock PLL and the pattern generator.
// PARAMETERS
//  CW         12    counter/timing field width (bits)
//  NUM_BANDS  4     number of vertical bands reported on v_band (>=2)
//  BW         2     width of v_band, >= clog2(NUM_BANDS)
//  HS_POL     1'b1  active level of hs (1 = active high)
//  VS_POL     1'b1  active level of vs
//  DEF_*      1080p60 reset timing: H 2199/43/189/2109, V 1124/4/40/1120, BAND_STEP 270
// PORTS
//  clk           in   1      pixel clock
//  reset_n       in   1      asynchronous active-low reset
//  en            in   1      1 = run; 0 = counters held at 0, outputs inactive
//  cfg_valid     in   1      new timing set offered
//  cfg_ready     out  1      1 = no change pending, cfg accepted on valid&ready
//  cfg_h         in   4*CW   {h_total,h_sync,h_start,h_end}
//  cfg_v         in   4*CW   {v_total,v_sync,v_start,v_end}
//  cfg_band_step in   CW     active lines per band
//  cfg_applied   out  1      1-cycle pulse when the shadow set becomes active
//  cfg_error     out  1      1-cycle pulse on a rejected (illegal) cfg handshake
//  hs, vs, de    out  1      sync/data-enable, registered
//  x, y          out  CW     active pixel/line coordinate (0-based), 0 when de=0
//  sof, sol      out  1      1-cycle start-of-frame / start-of-active-line pulses
//  v_band        out  BW     band index of current active line
// BEHAVIOUR
//  - Timing encoding: totals = total-1, sync = width-1; active H when h_start < hc <= h_end,
//    active V when v_start < vc <= v_end. hs asserted when hc <= h_sync; vs when vc <= v_sync.
//  - hc counts 0..h_total then wraps to 0, incrementing vc; vc wraps 0 after v_total.
//  - All outputs registered: 1-cycle latency from counter state to hs/vs/de/x/y/sof/sol/v_band.
//  - Reset: hc=vc=0, active set = DEF_*, no pending, cfg_ready=1, hs=~HS_POL, vs=~VS_POL,
//    de=0, x=y=0, sof=sol=cfg_applied=cfg_error=0, v_band=0.
//  - Config FSM: IDLE (cfg_ready=1) -> PENDING on valid&ready with legal set (captured into
//    shadow). PENDING (cfg_ready=0) -> IDLE on the cycle hc==h_total && vc==v_total, or any
//    cycle en=0: shadow copied to active, counters restart at 0, cfg_applied pulses.
//  - Legal set: h_sync < h_start < h_end <= h_total, v_sync < v_start < v_end <= v_total,
//    band_step != 0. Illegal: handshake completes (ready stays 1), nothing captured,
//    cfg_error pulses next cycle, state stays IDLE.
//  - cfg_valid while PENDING: not accepted; master must hold until ready.
//  - sof = registered (hc==0 && vc==0 && en); sol = first active pixel of an active line.
//  - v_band: 0 at first active line, +1 after every band_step active lines, saturates at
//    NUM_BANDS-1; reset to 0 at vc==0.
//  - en low: counters forced 0 next cycle, outputs inactive next cycle; en high resumes at hc=vc=0.
//  - reset_n low mid-frame: all state to reset values immediately, pending cfg discarded.
//  - All arithmetic unsigned CW bits; x = hc-h_start-1, y = vc-v_start-1 (no wrap within legal sets).
// TESTING
//  1 Reset, default 1080p: hs period 2200 clks, width 44; vs period 2200*1125; de 1920 clks/line,
//    1080 lines; v_band steps 0..3 every 270 lines.
//  2 Load H 9/1/2/7, V 5/0/1/4, step 1: applied only at frame end; then frame = 60 clks,
//    de 5 clks x 3 lines, x 0..4, y 0..2, v_band 0,1,2; cfg_applied one pulse.
//  3 cfg_valid held during PENDING -> cfg_ready=0, second set accepted only after cfg_applied.
//  4 Illegal set (h_end=12 > h_total=9) -> cfg_error pulse, timing unchanged, cfg_ready stays 1.
//  5 en dropped mid-line with pending cfg -> outputs inactive next clk, cfg applied, resume at sof.
//  6 reset_n asserted mid-frame with pending cfg -> outputs at reset values, DEF_* timing restored.

Source files
------------

// File: rtl/vpg_timing_core.sv
// vpg_timing_core
//   Runtime-programmable video timing generator. Free-running horizontal and
//   vertical counters are compared against an active timing set to produce
//   registered hs/vs/de, active pixel coordinates, frame/line strobes and a
//   vertical band index. A new timing set is accepted into a shadow copy and
//   only promoted to the active set at a frame boundary, or immediately while
//   en is low, so a frame is never built from a mix of two timing sets.
//
// Ports
//   clk, reset_n       pixel clock, asynchronous active-low reset
//   en                 1 = run, 0 = counters held at 0 and outputs inactive
//   cfg_valid/ready    handshake offering a new timing set
//   cfg_h, cfg_v       {total, sync, start, end}, totals and sync encoded as N-1
//   cfg_band_step      active lines per band
//   cfg_applied        pulse: shadow set has become the active set
//   cfg_error          pulse: an illegal set was offered and dropped
//   hs, vs, de         sync and data enable, registered
//   x, y               active pixel/line coordinate, 0 outside the active area
//   sof, sol           start-of-frame / start-of-active-line pulses
//   v_band             band index of the current active line
//
// Config FSM
//   state      | meaning
//   ST_IDLE    | no change pending, cfg_ready=1, offers are checked and captured
//   ST_PENDING | shadow set captured, waiting for frame end or en=0 to apply it
module vpg_timing_core #(
  parameter int       CW        = 12,
  parameter int       NUM_BANDS = 4,
  parameter int       BW        = 2,
  parameter logic     HS_POL    = 1'b1,
  parameter logic     VS_POL    = 1'b1,
  parameter logic [CW-1:0] DEF_H_TOTAL    = CW'(2199),
  parameter logic [CW-1:0] DEF_H_SYNC     = CW'(43),
  parameter logic [CW-1:0] DEF_H_START    = CW'(189),
  parameter logic [CW-1:0] DEF_H_END      = CW'(2109),
  parameter logic [CW-1:0] DEF_V_TOTAL    = CW'(1124),
  parameter logic [CW-1:0] DEF_V_SYNC     = CW'(4),
  parameter logic [CW-1:0] DEF_V_START    = CW'(40),
  parameter logic [CW-1:0] DEF_V_END      = CW'(1120),
  parameter logic [CW-1:0] DEF_BAND_STEP  = CW'(270)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [4*CW-1:0] cfg_h,
  input  logic [4*CW-1:0] cfg_v,
  input  logic [CW-1:0]   cfg_band_step,
  output logic            cfg_applied,
  output logic            cfg_error,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [CW-1:0]   x,
  output logic [CW-1:0]   y,
  output logic            sof,
  output logic            sol,
  output logic [BW-1:0]   v_band
);

  localparam logic [BW-1:0] BAND_MAX = BW'(NUM_BANDS - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_PENDING} cfg_state_t;

  cfg_state_t state, state_nxt;

  logic [CW-1:0] hc, vc;

  logic [CW-1:0] h_total, h_sync, h_start, h_end;
  logic [CW-1:0] v_total, v_sync, v_start, v_end;
  logic [CW-1:0] band_step;

  logic [CW-1:0] s_h_total, s_h_sync, s_h_start, s_h_end;
  logic [CW-1:0] s_v_total, s_v_sync, s_v_start, s_v_end;
  logic [CW-1:0] s_band_step;

  logic [CW-1:0] c_h_total, c_h_sync, c_h_start, c_h_end;
  logic [CW-1:0] c_v_total, c_v_sync, c_v_start, c_v_end;

  logic [CW-1:0] band_line;
  logic [BW-1:0] band_idx;

  logic cfg_legal, take, reject, apply;
  logic line_end, frame_end, h_act, v_act, act;

  assign c_h_total = cfg_h[4*CW-1 -: CW];
  assign c_h_sync  = cfg_h[3*CW-1 -: CW];
  assign c_h_start = cfg_h[2*CW-1 -: CW];
  assign c_h_end   = cfg_h[CW-1:0];
  assign c_v_total = cfg_v[4*CW-1 -: CW];
  assign c_v_sync  = cfg_v[3*CW-1 -: CW];
  assign c_v_start = cfg_v[2*CW-1 -: CW];
  assign c_v_end   = cfg_v[CW-1:0];

  assign cfg_legal = (c_h_sync < c_h_start) && (c_h_start < c_h_end) && (c_h_end <= c_h_total) &&
                     (c_v_sync < c_v_start) && (c_v_start < c_v_end) && (c_v_end <= c_v_total) &&
                     (cfg_band_step != '0);

  assign line_end  = (hc == h_total);
  assign frame_end = line_end && (vc == v_total);
  assign h_act     = (hc > h_start) && (hc <= h_end);
  assign v_act     = (vc > v_start) && (vc <= v_end);
  assign act       = en && h_act && v_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    take      = 1'b0;
    reject    = 1'b0;
    apply     = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (cfg_legal) begin
            take      = 1'b1;
            state_nxt = ST_PENDING;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (!en || frame_end) begin
          apply     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_h_total <= DEF_H_TOTAL; s_h_sync <= DEF_H_SYNC;
      s_h_start <= DEF_H_START; s_h_end  <= DEF_H_END;
      s_v_total <= DEF_V_TOTAL; s_v_sync <= DEF_V_SYNC;
      s_v_start <= DEF_V_START; s_v_end  <= DEF_V_END;
      s_band_step <= DEF_BAND_STEP;
    end else if (take) begin
      s_h_total <= c_h_total; s_h_sync <= c_h_sync;
      s_h_start <= c_h_start; s_h_end  <= c_h_end;
      s_v_total <= c_v_total; s_v_sync <= c_v_sync;
      s_v_start <= c_v_start; s_v_end  <= c_v_end;
      s_band_step <= cfg_band_step;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total <= DEF_H_TOTAL; h_sync <= DEF_H_SYNC;
      h_start <= DEF_H_START; h_end  <= DEF_H_END;
      v_total <= DEF_V_TOTAL; v_sync <= DEF_V_SYNC;
      v_start <= DEF_V_START; v_end  <= DEF_V_END;
      band_step <= DEF_BAND_STEP;
    end else if (apply) begin
      h_total <= s_h_total; h_sync <= s_h_sync;
      h_start <= s_h_start; h_end  <= s_h_end;
      v_total <= s_v_total; v_sync <= s_v_sync;
      v_start <= s_v_start; v_end  <= s_v_end;
      band_step <= s_band_step;
    end
  end

  // An apply always lands on a frame boundary or while en is low, so forcing
  // the counters to 0 on apply only matters for the en-low case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!en || apply || frame_end) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= vc + CW'(1);
    end else begin
      hc <= hc + CW'(1);
    end
  end

  // Band tracking advances at the end of each active line; vc=0 is never an
  // active line, so clearing at the frame wrap restarts the index at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      band_line <= '0;
      band_idx  <= '0;
    end else if (!en || apply || frame_end) begin
      band_line <= '0;
      band_idx  <= '0;
    end else if (line_end && v_act) begin
      if (band_line + CW'(1) == band_step) begin
        band_line <= '0;
        if (band_idx != BAND_MAX) band_idx <= band_idx + BW'(1);
      end else begin
        band_line <= band_line + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      sof         <= 1'b0;
      sol         <= 1'b0;
      v_band      <= '0;
      cfg_applied <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      hs          <= (en && (hc <= h_sync)) ? HS_POL : ~HS_POL;
      vs          <= (en && (vc <= v_sync)) ? VS_POL : ~VS_POL;
      de          <= act;
      x           <= act ? (hc - h_start - CW'(1)) : '0;
      y           <= act ? (vc - v_start - CW'(1)) : '0;
      sof         <= en && (hc == '0) && (vc == '0);
      sol         <= en && v_act && (hc == h_start + CW'(1));
      v_band      <= (en && v_act) ? band_idx : '0;
      cfg_applied <= apply;
      cfg_error   <= reject;
    end
  end

endmodule

// File: tb/tb_vpg_timing_core.sv
module tb_vpg_timing_core;
  localparam int CW = 12;
  localparam int BW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            en;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [4*CW-1:0] cfg_h;
  logic [4*CW-1:0] cfg_v;
  logic [CW-1:0]   cfg_band_step;
  logic            cfg_applied;
  logic            cfg_error;
  logic            hs, vs, de;
  logic [CW-1:0]   x, y;
  logic            sof, sol;
  logic [BW-1:0]   v_band;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vpg_timing_core #(.CW(CW), .NUM_BANDS(4), .BW(BW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_band_step(cfg_band_step),
    .cfg_applied(cfg_applied), .cfg_error(cfg_error),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .sof(sof), .sol(sol), .v_band(v_band)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] pk(input int a, input int b, input int c, input int d);
    return {CW'(a), CW'(b), CW'(c), CW'(d)};
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_hs"}, hs, 0);
    chk({pfx, "_vs"}, vs, 0);
    chk({pfx, "_de"}, de, 0);
    chk({pfx, "_x"}, x, 0);
    chk({pfx, "_y"}, y, 0);
    chk({pfx, "_sof"}, sof, 0);
    chk({pfx, "_sol"}, sol, 0);
    chk({pfx, "_vband"}, v_band, 0);
    chk({pfx, "_ready"}, cfg_ready, 1);
    chk({pfx, "_applied"}, cfg_applied, 0);
    chk({pfx, "_error"}, cfg_error, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_hs, n_vs, n_de, n_sof, n_sol, n_app, n_rdy, n_bad, j, k;
    int first_de, first_sol;
    logic [4*CW-1:0] ill_h [3];
    logic [4*CW-1:0] ill_v [3];
    logic [CW-1:0]   ill_s [3];

    reset_n = 1'b0; en = 1'b1; cfg_valid = 1'b0;
    cfg_h = '0; cfg_v = '0; cfg_band_step = '0;

    // 1: reset state and default 1080p line 0
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("def_first_sof", sof, 1);
    chk("def_first_hs", hs, 1);
    n_hs = 0; n_vs = 0; n_de = 0; n_sof = 0;
    for (int i = 0; i < 2200; i++) begin
      if (i > 0) @(negedge clk);
      n_hs += int'(hs); n_vs += int'(vs); n_de += int'(de); n_sof += int'(sof);
    end
    chk("def_hs_width", n_hs, 44);
    chk("def_vs_line0", n_vs, 2200);
    chk("def_de_line0", n_de, 0);
    chk("def_sof_line0", n_sof, 1);
    @(negedge clk);
    chk("def_hs_period", hs, 1);
    chk("def_no_sof_line1", sof, 0);

    // 2/5: load small set, not applied mid-frame, applied by en drop
    cfg_valid = 1'b1; cfg_h = pk(9, 1, 2, 7); cfg_v = pk(5, 0, 1, 4); cfg_band_step = CW'(1);
    @(negedge clk);
    chk("a_pending_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    n_app = 0; n_rdy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_app += int'(cfg_applied); n_rdy += int'(cfg_ready);
    end
    chk("a_not_applied_midframe", n_app, 0);
    chk("a_ready_low_pending", n_rdy, 0);
    chk("vs_before_en_drop", vs, 1);
    en = 1'b0;
    @(negedge clk);
    chk("en0_applied", cfg_applied, 1);
    chk("en0_vs", vs, 0);
    chk("en0_hs", hs, 0);
    chk("en0_de", de, 0);
    chk("en0_ready", cfg_ready, 1);
    en = 1'b1;
    @(negedge clk);
    chk("a_resume_sof", sof, 1);
    chk("a_applied_one_pulse", cfg_applied, 0);

    n_hs = 0; n_vs = 0; n_de = 0; n_sof = 0; n_sol = 0; n_app = 0; n_bad = 0;
    j = 0; first_de = -1; first_sol = -1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      n_hs += int'(hs); n_vs += int'(vs); n_sof += int'(sof);
      n_sol += int'(sol); n_app += int'(cfg_applied);
      if (sol && first_sol < 0) first_sol = i;
      if (de) begin
        if (first_de < 0) first_de = i;
        chk("a_x", x, j % 5);
        chk("a_y", y, j / 5);
        chk("a_vband", v_band, j / 5);
        j++;
      end else if (x != 0 || y != 0) begin
        n_bad++;
      end
    end
    chk("a_de_count", j, 15);
    chk("a_hs_count", n_hs, 12);
    chk("a_vs_count", n_vs, 10);
    chk("a_sof_count", n_sof, 1);
    chk("a_sol_count", n_sol, 3);
    chk("a_first_de", first_de, 23);
    chk("a_first_sol", first_sol, 23);
    chk("a_xy_zero_outside", n_bad, 0);
    chk("a_applied_frame", n_app, 0);
    @(negedge clk);
    chk("a_frame_period", sof, 1);

    // 3: second set offered while pending waits for the frame-end apply
    cfg_valid = 1'b1; cfg_band_step = CW'(2);
    @(negedge clk);
    chk("a2_pending_ready", cfg_ready, 0);
    cfg_h = pk(11, 2, 3, 9); cfg_v = pk(3, 0, 1, 3); cfg_band_step = CW'(1);
    k = 61; n_rdy = 0;
    while (!cfg_applied && k < 200) begin
      n_rdy += int'(cfg_ready);
      @(negedge clk);
      k++;
    end
    chk("a2_apply_at_frame_end", k, 119);
    chk("b_held_not_accepted", n_rdy, 0);
    chk("a2_ready_after_apply", cfg_ready, 1);
    @(negedge clk);
    chk("b_accepted_after_apply", cfg_ready, 0);
    chk("a2_sof", sof, 1);
    cfg_valid = 1'b0;
    n_app = 0; j = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      n_app += int'(cfg_applied);
      if (de) begin
        chk("a2_vband", v_band, (j < 10) ? 0 : 1);
        j++;
      end
      if (i == 59) chk("b_applied_frame_end", cfg_applied, 1);
    end
    chk("a2_de_count", j, 15);
    chk("a2_applied_once", n_app, 1);
    @(negedge clk);
    chk("b_sof", sof, 1);
    chk("b_ready", cfg_ready, 1);
    n_hs = 0; n_vs = 0; n_de = 0; n_sof = 0; n_sol = 0;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      n_hs += int'(hs); n_vs += int'(vs); n_de += int'(de);
      n_sof += int'(sof); n_sol += int'(sol);
    end
    chk("b_hs_count", n_hs, 12);
    chk("b_vs_count", n_vs, 12);
    chk("b_de_count", n_de, 12);
    chk("b_sof_count", n_sof, 1);
    chk("b_sol_count", n_sol, 2);
    @(negedge clk);
    chk("b_frame_period", sof, 1);

    // 4: illegal sets rejected
    ill_h[0] = pk(9, 1, 2, 12);  ill_v[0] = pk(3, 0, 1, 3); ill_s[0] = CW'(1);
    ill_h[1] = pk(11, 2, 3, 9);  ill_v[1] = pk(3, 1, 1, 3); ill_s[1] = CW'(1);
    ill_h[2] = pk(11, 2, 3, 9);  ill_v[2] = pk(3, 0, 1, 3); ill_s[2] = CW'(0);
    for (int t = 0; t < 3; t++) begin
      cfg_valid = 1'b1; cfg_h = ill_h[t]; cfg_v = ill_v[t]; cfg_band_step = ill_s[t];
      @(negedge clk);
      chk($sformatf("ill%0d_error", t), cfg_error, 1);
      chk($sformatf("ill%0d_ready", t), cfg_ready, 1);
      cfg_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("ill%0d_error_pulse", t), cfg_error, 0);
    end
    n_de = 0; n_sof = 0; n_hs = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      n_de += int'(de); n_sof += int'(sof); n_hs += int'(hs);
    end
    chk("ill_timing_de", n_de, 12);
    chk("ill_timing_sof", n_sof, 1);
    chk("ill_timing_hs", n_hs, 12);

    // 6: reset mid-frame with pending set
    cfg_valid = 1'b1; cfg_h = pk(9, 1, 2, 7); cfg_v = pk(5, 0, 1, 4); cfg_band_step = CW'(1);
    @(negedge clk);
    chk("r_pending_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("r_hs_before", hs, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("r_first_sof", sof, 1);
    n_hs = 0; n_app = 0; n_rdy = 0; n_sof = 0;
    for (int i = 0; i < 2200; i++) begin
      if (i > 0) @(negedge clk);
      n_hs += int'(hs); n_app += int'(cfg_applied);
      n_rdy += int'(cfg_ready); n_sof += int'(sof);
    end
    chk("r_def_hs_width", n_hs, 44);
    chk("r_pending_discarded", n_app, 0);
    chk("r_ready_high", n_rdy, 2200);
    chk("r_sof_count", n_sof, 1);
    @(negedge clk);
    chk("r_def_hs_period", hs, 1);
    chk("r_def_no_sof", sof, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
